fetch_stage: RTL and testbench

//  Synthesizable instruction-fetch stage for the 64-bit LEGv8 datapath; sits directly upstream of decode.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_byte_assembler.sv | 51 +++++
 rtl/fetch_stage.sv | 155 +++++++++++++++
 tb/tb_fetch_stage.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
// Holds the fetch FSM state enum, instruction-format constants and the HALT decode helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH,
        DRAIN,
        HOLD,
        HALTED
    } fetch_state_t;

    localparam int unsigned INSTR_W         = 32;
    localparam int unsigned BYTES_PER_INSTR = 4;
    localparam logic [10:0] HALT_OPCODE     = 11'h7FF;
    localparam int unsigned PC_INC          = 4;

    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1:INSTR_W-11] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/fetch_byte_assembler.sv
// Collects four byte-wide memory reads into one little-endian instruction word.
// done pulses in the cycle the final byte arrives; word is valid in that same cycle.
module fetch_byte_assembler
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic [INSTR_W-1:0] word,
    output logic               done
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_INSTR - 1);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] lanes_q, lanes_d;

    always_comb begin
        cnt_d   = cnt_q;
        lanes_d = lanes_q;
        if (clear) begin
            cnt_d   = 2'd0;
            lanes_d = '0;
        end else if (byte_valid) begin
            cnt_d = cnt_q + 2'd1;
            unique case (cnt_q)
                2'd0:    lanes_d[7:0]   = byte_data;
                2'd1:    lanes_d[15:8]  = byte_data;
                2'd2:    lanes_d[23:16] = byte_data;
                default: lanes_d        = lanes_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            lanes_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            lanes_q <= lanes_d;
        end
    end

    // The top byte bypasses the register so the word is complete on the done cycle.
    assign word = {byte_data, lanes_q};
    assign done = byte_valid && !clear && (cnt_q == LAST_IDX);

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 fetch stage: four byte reads per instruction, valid/ready hand-off to decode,
// branch redirect and HALT detection. Define ALIGN_CHECK_EN to trap misaligned redirects.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     PC_W     = 64,
    parameter int unsigned     IMEM_AW  = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_rd_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [7:0]         imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               pc_src,
    input  logic [PC_W-1:0]    branch_addr,
    output logic               halted,
    output logic               align_err
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_INSTR - 1);

    fetch_state_t       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [1:0]         idx_q, idx_d;
    logic               halted_q, halted_d;
    logic               align_err_q, align_err_d;
    logic               rd_valid_q;
    logic               fetch_rd;
    logic               redirect;
    logic               asm_done;
    logic [INSTR_W-1:0] asm_word;

    assign redirect = pc_src && (state_q != HALTED);

    fetch_byte_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (redirect),
        .byte_valid (rd_valid_q),
        .byte_data  (imem_rdata),
        .word       (asm_word),
        .done       (asm_done)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        idx_d       = idx_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        halted_d    = halted_q;
        align_err_d = align_err_q;
        fetch_rd    = 1'b0;

        unique case (state_q)
            FETCH: begin
                fetch_rd = 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = 2'd0;
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            DRAIN: begin
                if (asm_done) begin
                    if (is_halt(asm_word)) begin
                        halted_d = 1'b1;
                        state_d  = HALTED;
                    end else begin
                        instr_d    = asm_word;
                        instr_pc_d = pc_q;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    pc_d    = pc_q + PC_W'(PC_INC);
                    state_d = FETCH;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: state_d = FETCH;
        endcase

        // A redirect overrides everything above, including a same-cycle handshake or HALT.
        if (redirect) begin
            fetch_rd   = 1'b0;
            idx_d      = 2'd0;
            state_d    = FETCH;
            instr_d    = instr_q;
            instr_pc_d = instr_pc_q;
            halted_d   = halted_q;
            pc_d       = pc_q;
`ifdef ALIGN_CHECK_EN
            if (branch_addr[1:0] != 2'b00) begin
                halted_d    = 1'b1;
                align_err_d = 1'b1;
                state_d     = HALTED;
            end else begin
                pc_d = branch_addr;
            end
`else
            pc_d = {branch_addr[PC_W-1:2], 2'b00};
`endif
        end
    end

`ifndef ALIGN_CHECK_EN
    logic unused_branch_lsb;
    assign unused_branch_lsb = ^branch_addr[1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            idx_q       <= 2'd0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            halted_q    <= 1'b0;
            align_err_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            idx_q       <= idx_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            halted_q    <= halted_d;
            align_err_q <= align_err_d;
            rd_valid_q  <= imem_rd_en;
        end
    end

    // Gating with rst_n keeps the strobe low while reset is held.
    assign imem_rd_en  = fetch_rd && rst_n;
    assign imem_addr   = pc_q[IMEM_AW-1:0] + IMEM_AW'(idx_q);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = (state_q == HOLD);
    assign halted      = halted_q;
    assign align_err   = align_err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: random memory image and random redirects,
// with expected fetch addresses and instruction words derived from a byte-array memory model.
module tb_fetch_stage;

    localparam int unsigned PC_W    = 64;
    localparam int unsigned IMEM_AW = 12;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               imem_rd_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [7:0]         imem_rdata;
    logic [31:0]        instr;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               pc_src;
    logic [PC_W-1:0]    branch_addr;
    logic               halted;
    logic               align_err;

    logic [7:0]  mem [4096];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] model_pc;

    fetch_stage #(
        .PC_W     (PC_W),
        .IMEM_AW  (IMEM_AW),
        .RESET_PC (64'd0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_rd_en  (imem_rd_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_src      (pc_src),
        .branch_addr (branch_addr),
        .halted      (halted),
        .align_err   (align_err)
    );

    always #5 clk = ~clk;

    // Byte memory with one-cycle read latency; junk when not read.
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
        else            imem_rdata <= 8'($urandom);
    end

    function automatic logic [31:0] word_at(input logic [63:0] pc);
        logic [11:0] a;
        a = pc[11:0];
        return {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            rst_n = 1'b0;
            mid();
            chk("reset_rd_en", 64'(imem_rd_en), 64'd0);
            if (i > 0) begin
                chk("reset_valid", 64'(instr_valid), 64'd0);
                chk("reset_halted", 64'(halted), 64'd0);
                chk("reset_align_err", 64'(align_err), 64'd0);
                chk("reset_instr", 64'(instr), 64'd0);
                chk("reset_instr_pc", instr_pc, 64'd0);
            end
        end
        tick();
        rst_n = 1'b1;
        mid();
        model_pc = 64'd0;
    endtask

    task automatic wait_rd();
        int w;
        w = 0;
        while (!imem_rd_en && w < 8) begin
            tick();
            mid();
            w++;
        end
        chk("rd_start_delay", 64'(w), 64'd0);
    endtask

    task automatic run_instr(input int delay, input bit redir, input logic [63:0] tgt);
        logic [31:0] exp_w;
        logic [11:0] ea;
        exp_w = word_at(model_pc);
        wait_rd();
        for (int k = 0; k < 4; k++) begin
            ea = model_pc[11:0] + 12'(k);
            chk("rd_en", 64'(imem_rd_en), 64'd1);
            chk("rd_addr", 64'(imem_addr), 64'(ea));
            chk("early_valid", 64'(instr_valid), 64'd0);
            instr_ready = 1'($urandom);
            tick();
            mid();
        end
        chk("drain_rd_en", 64'(imem_rd_en), 64'd0);
        chk("drain_valid", 64'(instr_valid), 64'd0);
        tick();
        mid();
        chk("valid", 64'(instr_valid), 64'd1);
        chk("instr", 64'(instr), 64'(exp_w));
        chk("instr_pc", instr_pc, model_pc);
        chk("hold_halted", 64'(halted), 64'd0);
        if (redir) begin
            instr_ready = 1'b1;
            pc_src      = 1'b1;
            branch_addr = tgt;
            tick();
            pc_src = 1'b0;
            mid();
            model_pc = tgt & ~64'd3;
            chk("valid_after_redir", 64'(instr_valid), 64'd0);
        end else begin
            instr_ready = (delay == 0);
            for (int d = 0; d < delay; d++) begin
                tick();
                mid();
                chk("hold_valid", 64'(instr_valid), 64'd1);
                chk("hold_instr", 64'(instr), 64'(exp_w));
                chk("hold_pc", instr_pc, model_pc);
                chk("hold_rd_en", 64'(imem_rd_en), 64'd0);
                if (d == delay - 1) instr_ready = 1'b1;
            end
            tick();
            mid();
            instr_ready = 1'b0;
            model_pc    = model_pc + 64'd4;
            chk("valid_after_hs", 64'(instr_valid), 64'd0);
        end
    endtask

    // Redirect issued during cycle k of a fetch (k = 4 is the drain cycle).
    task automatic abort_fetch(input int k, input logic [63:0] tgt);
        logic [11:0] ea;
        wait_rd();
        for (int i = 0; i < k; i++) begin
            if (i < 4) begin
                ea = model_pc[11:0] + 12'(i);
                chk("abort_rd_addr", 64'(imem_addr), 64'(ea));
            end
            chk("abort_valid", 64'(instr_valid), 64'd0);
            tick();
            mid();
        end
        pc_src      = 1'b1;
        branch_addr = tgt;
        #1;
        chk("redir_rd_en", 64'(imem_rd_en), 64'd0);
        tick();
        pc_src = 1'b0;
        mid();
        chk("redir_valid", 64'(instr_valid), 64'd0);
`ifdef ALIGN_CHECK_EN
        if (tgt[1:0] != 2'b00) begin
            chk("align_halted", 64'(halted), 64'd1);
            chk("align_err", 64'(align_err), 64'd1);
            chk("align_rd_en", 64'(imem_rd_en), 64'd0);
        end else begin
            model_pc = tgt;
        end
`else
        chk("align_err_tied", 64'(align_err), 64'd0);
        model_pc = tgt & ~64'd3;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [63:0] tgt;
        int          op;

        rst_n       = 1'b0;
        instr_ready = 1'b0;
        pc_src      = 1'b0;
        branch_addr = '0;
        model_pc    = 64'd0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        for (int i = 3; i < 4096; i += 4) if (mem[i] == 8'hFF) mem[i] = 8'hFE;
        mem[0] = 8'h8B; mem[1] = 8'h02; mem[2] = 8'h1F; mem[3] = 8'h8B;

        do_reset(3);
        chk("first_word_model", 64'(word_at(64'd0)), 64'h8B1F028B);
        run_instr(0, 1'b0, 64'd0);
        run_instr(10, 1'b0, 64'd0);
        abort_fetch(1, 64'h40);
        run_instr(0, 1'b1, 64'h100);
        run_instr(0, 1'b0, 64'd0);

        for (int it = 0; it < 10; it++) begin
            op  = int'($urandom_range(2, 0));
            tgt = {32'($urandom), 32'($urandom)};
`ifdef ALIGN_CHECK_EN
            tgt[1:0] = 2'b00;
`endif
            case (op)
                0:       run_instr(int'($urandom_range(3, 0)), 1'b0, 64'd0);
                1:       abort_fetch(int'($urandom_range(4, 0)), tgt);
                default: run_instr(0, 1'b1, tgt & ~64'd3);
            endcase
        end

        // PC and address wrap.
        abort_fetch(2, 64'hFFFF_FFFF_FFFF_FFFC);
        run_instr(1, 1'b0, 64'd0);
        run_instr(0, 1'b0, 64'd0);

        abort_fetch(0, 64'h42);
`ifdef ALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            mid();
            chk("align_sticky", 64'(align_err), 64'd1);
            chk("align_no_rd", 64'(imem_rd_en), 64'd0);
        end
        do_reset(2);
`else
        chk("masked_target", model_pc, 64'h40);
        run_instr(0, 1'b0, 64'd0);
`endif

        // Reset in the middle of a fetch.
        wait_rd();
        tick();
        mid();
        tick();
        rst_n = 1'b0;
        mid();
        chk("midreset_rd_en", 64'(imem_rd_en), 64'd0);
        chk("midreset_valid", 64'(instr_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        mid();
        model_pc = 64'd0;
        run_instr(0, 1'b0, 64'd0);

        // HALT word at 0x8.
        mem[8] = 8'h00; mem[9] = 8'h00; mem[10] = 8'hE0; mem[11] = 8'hFF;
        run_instr(0, 1'b0, 64'd0);
        chk("halt_pc", model_pc, 64'd8);
        wait_rd();
        for (int k = 0; k < 4; k++) begin
            chk("halt_rd_addr", 64'(imem_addr), 64'(8 + k));
            tick();
            mid();
        end
        tick();
        mid();
        for (int i = 0; i < 5; i++) begin
            chk("halted", 64'(halted), 64'd1);
            chk("halt_valid", 64'(instr_valid), 64'd0);
            chk("halt_rd_en", 64'(imem_rd_en), 64'd0);
            tick();
            pc_src      = (i == 1);
            branch_addr = 64'h40;
            mid();
        end
        pc_src = 1'b0;
        chk("halt_ignores_redir", 64'(imem_rd_en), 64'd0);
        chk("halt_sticky", 64'(halted), 64'd1);

        do_reset(2);
        chk("post_reset_halted", 64'(halted), 64'd0);
        run_instr(0, 1'b0, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
